// File: rtl/regfile_if.sv
// Register-file access bundle: two decode read ports, one write-back port,
// plus the debug read port and committed-write counter.
interface regfile_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [31:0]   wr_cnt;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    input  rdata1, rdata2, dbg_data, wr_cnt
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2, dbg_addr,
    output rdata1, rdata2, dbg_data, wr_cnt
  );
endinterface

// File: rtl/regfile.sv
// 32 x 32 MIPS register file: two combinational read ports with same-cycle
// write-through bypass, one write port, registered debug read, write counter.
module regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  bus
);
  localparam int NREG = 1 << AW;

  logic [DW-1:0] mem [NREG];
  logic [DW-1:0] dbg_q;
  logic [31:0]   cnt;

  // Priority: reset, enable, $0, bypass of the in-flight write, stored value.
  function automatic logic [DW-1:0] read_port(
    input logic          rst_n_now,
    input logic          en,
    input logic [AW-1:0] a,
    input logic          w_en,
    input logic [AW-1:0] wa,
    input logic [DW-1:0] wd,
    input logic [DW-1:0] stored
  );
    if (!rst_n_now || !en || a == '0) return '0;
    if (w_en && wa == a)              return wd;
    return stored;
  endfunction

  // Write-back / debug stage; mem[0] is cleared on reset and never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      dbg_q <= '0;
      cnt   <= '0;
    end else begin
      if (bus.we && bus.waddr != '0) begin
        mem[bus.waddr] <= bus.wdata;
        cnt            <= cnt + 32'd1;
      end
      dbg_q <= (bus.dbg_addr == '0) ? '0 : mem[bus.dbg_addr];
    end
  end

  assign bus.rdata1   = read_port(rst, bus.re1, bus.raddr1, bus.we, bus.waddr,
                                  bus.wdata, mem[bus.raddr1]);
  assign bus.rdata2   = read_port(rst, bus.re2, bus.raddr2, bus.we, bus.waddr,
                                  bus.wdata, mem[bus.raddr2]);
  assign bus.dbg_data = dbg_q;
  assign bus.wr_cnt   = cnt;
endmodule
